// File: rtl/rx_datapath.sv
// Receive datapath: shifts in frame bits, remaps them to a byte, checks parity/stop and keeps sticky status.
// Optional break detection (brk output) is built when RX_BREAK_DET_EN is defined.
module rx_datapath #(
  parameter int OVF_KEEP_OLD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       start,
  input  logic       btu,
  input  logic       done,
  input  logic       eight,
  input  logic       p_en,
  input  logic       ohel,
  input  logic       rd_data,
  input  logic       rd_stat,
  output logic [7:0] data,
`ifdef RX_BREAK_DET_EN
  output logic       brk,
`endif
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  logic [9:0] sr_q, sr_d;
  logic [7:0] data_q, data_d;
  logic       rxrdy_q, rxrdy_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovf_q, ovf_d;
  logic [7:0] byte_s;
  logic       par_exp_s;
  logic       par_err_s;
  logic       ovr_s;
  logic       ferr_set_s;
`ifdef RX_BREAK_DET_EN
  logic       brk_q, brk_d;
  logic       brk_s;
`endif

  function automatic logic xor_reduce(input logic [7:0] b);
    return ^b;
  endfunction

  // Byte remap, parity check, overrun and framing decisions for the frame held in sr_q
  always_comb begin
    byte_s = 8'h00;
    case ({eight, p_en})
      2'b00:   byte_s = {1'b0, sr_q[8:2]};
      2'b01:   byte_s = {1'b0, sr_q[7:1]};
      2'b10:   byte_s = sr_q[8:1];
      2'b11:   byte_s = sr_q[7:0];
      default: byte_s = 8'h00;
    endcase
    if (ohel) begin
      par_exp_s = ~xor_reduce(byte_s);
    end else begin
      par_exp_s = xor_reduce(byte_s);
    end
    par_err_s = p_en & (par_exp_s != sr_q[8]);
    ovr_s     = done & rxrdy_q & ~rd_data;
`ifdef RX_BREAK_DET_EN
    // An all-zero frame is a break, not a framing error
    brk_s      = (byte_s == 8'h00) & ~(p_en & sr_q[8]) & ~sr_q[9];
    ferr_set_s = done & ~sr_q[9] & ~brk_s;
`else
    ferr_set_s = done & ~sr_q[9];
`endif
  end

  // Next-state for shift register, data register and sticky flags (set beats clear)
  always_comb begin
    sr_d    = sr_q;
    data_d  = data_q;
    rxrdy_d = rxrdy_q;
    if (done) begin
      sr_d    = 10'h3FF;
      rxrdy_d = 1'b1;
      if (ovr_s && (OVF_KEEP_OLD != 0)) begin
        data_d = data_q;
      end else begin
        data_d = byte_s;
      end
    end else if (btu && !start) begin
      sr_d = {rx, sr_q[9:1]};
    end else begin
      sr_d = sr_q;
    end
    if (!done && rd_data) begin
      rxrdy_d = 1'b0;
    end else begin
      rxrdy_d = rxrdy_d;
    end
    perr_d = (perr_q & ~rd_stat) | (done & par_err_s);
    ferr_d = (ferr_q & ~rd_stat) | ferr_set_s;
    ovf_d  = (ovf_q & ~rd_stat) | ovr_s;
`ifdef RX_BREAK_DET_EN
    brk_d  = (brk_q & ~rd_stat) | (done & brk_s);
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= 10'h3FF;
      data_q  <= 8'h00;
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef RX_BREAK_DET_EN
      brk_q   <= 1'b0;
`endif
    end else begin
      sr_q    <= sr_d;
      data_q  <= data_d;
      rxrdy_q <= rxrdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
`ifdef RX_BREAK_DET_EN
      brk_q   <= brk_d;
`endif
    end
  end

  assign data  = data_q;
  assign rxrdy = rxrdy_q;
  assign perr  = perr_q;
  assign ferr  = ferr_q;
  assign ovf   = ovf_q;
`ifdef RX_BREAK_DET_EN
  assign brk   = brk_q;
`endif

endmodule

// File: tb/tb_rx_datapath.sv
// Directed self-checking bench for rx_datapath; u_new overwrites on overrun, u_old keeps the old byte.
module tb_rx_datapath;

  logic       clk = 1'b0;
  logic       rst, rx, start, btu, done, eight, p_en, ohel, rd_data, rd_stat;
  logic [7:0] data0, data1;
  logic       rxrdy0, perr0, ferr0, ovf0;
  logic       rxrdy1, perr1, ferr1, ovf1;
`ifdef RX_BREAK_DET_EN
  logic       brk0, brk1;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rx_datapath #(.OVF_KEEP_OLD(0)) u_new (
    .clk(clk), .rst(rst), .rx(rx), .start(start), .btu(btu), .done(done),
    .eight(eight), .p_en(p_en), .ohel(ohel), .rd_data(rd_data), .rd_stat(rd_stat),
    .data(data0),
`ifdef RX_BREAK_DET_EN
    .brk(brk0),
`endif
    .rxrdy(rxrdy0), .perr(perr0), .ferr(ferr0), .ovf(ovf0)
  );

  rx_datapath #(.OVF_KEEP_OLD(1)) u_old (
    .clk(clk), .rst(rst), .rx(rx), .start(start), .btu(btu), .done(done),
    .eight(eight), .p_en(p_en), .ohel(ohel), .rd_data(rd_data), .rd_stat(rd_stat),
    .data(data1),
`ifdef RX_BREAK_DET_EN
    .brk(brk1),
`endif
    .rxrdy(rxrdy1), .perr(perr1), .ferr(ferr1), .ovf(ovf1)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // start phase (with a btu that must not shift), then n bits LSB first, then done
  task automatic send(input logic [9:0] bits, input int n, input logic rdd);
    start = 1'b1; btu = 1'b1; rx = 1'b0; cyc();
    btu = 1'b0; cyc();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx = bits[i]; btu = 1'b1; cyc();
      btu = 1'b0; cyc();
    end
    rx = 1'b1; done = 1'b1; rd_data = rdd; cyc();
    done = 1'b0; rd_data = 1'b0;
  endtask

  task automatic clear_all();
    rd_data = 1'b1; rd_stat = 1'b1; cyc();
    rd_data = 1'b0; rd_stat = 1'b0;
  endtask

  task automatic mode(input logic e, input logic p, input logic o);
    eight = e; p_en = p; ohel = o;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0;
    chk("reset_data", data0, 8'h00);
    chk("reset_flags", {4'h0, rxrdy0, perr0, ferr0, ovf0}, 8'h00);
  endtask

  task automatic test_8p_odd();
    mode(1'b1, 1'b1, 1'b1);
    send({1'b1, 1'b1, 8'hA5}, 10, 1'b0);
    chk("8p_odd_data", data0, 8'hA5);
    chk("8p_odd_flags", {4'h0, rxrdy0, perr0, ferr0, ovf0}, 8'h08);
    clear_all();
  endtask

  task automatic test_7bit();
    mode(1'b0, 1'b0, 1'b0);
    send({2'b11, 1'b1, 7'h41}, 8, 1'b0);
    chk("7n_data", data0, 8'h41);
    chk("7n_rxrdy", {7'h0, rxrdy0}, 8'h01);
    rd_data = 1'b1; cyc(); rd_data = 1'b0;
    chk("7n_rd_clears", {7'h0, rxrdy0}, 8'h00);
    mode(1'b0, 1'b1, 1'b1);
    send({1'b1, 1'b1, 1'b1, 7'h55}, 9, 1'b0);
    chk("7p_odd_data", data0, 8'h55);
    chk("7p_odd_flags", {4'h0, rxrdy0, perr0, ferr0, ovf0}, 8'h08);
    clear_all();
  endtask

  task automatic test_parity();
    mode(1'b1, 1'b1, 1'b0);
    send({1'b1, 1'b1, 8'h03}, 10, 1'b0);
    chk("perr_set", {7'h0, perr0}, 8'h01);
    rd_data = 1'b1; cyc(); rd_data = 1'b0;
    send({1'b1, 1'b0, 8'h03}, 10, 1'b0);
    chk("perr_sticky", {7'h0, perr0}, 8'h01);
    chk("perr_good_data", data0, 8'h03);
    rd_stat = 1'b1; cyc(); rd_stat = 1'b0;
    chk("perr_cleared", {7'h0, perr0}, 8'h00);
    rd_data = 1'b1; cyc(); rd_data = 1'b0;
    // rd_stat coincident with an erroring done: set wins
    rd_stat = 1'b1;
    send({1'b1, 1'b1, 8'h03}, 10, 1'b0);
    rd_stat = 1'b0;
    chk("perr_set_wins", {7'h0, perr0}, 8'h01);
    clear_all();
  endtask

  task automatic test_framing();
    mode(1'b1, 1'b0, 1'b0);
    send({1'b1, 1'b0, 8'hFF}, 9, 1'b0);
    chk("ferr_set", {7'h0, ferr0}, 8'h01);
    chk("ferr_data", data0, 8'hFF);
    clear_all();
    chk("ferr_cleared", {7'h0, ferr0}, 8'h00);
    send({1'b1, 1'b0, 8'h00}, 9, 1'b0);
`ifdef RX_BREAK_DET_EN
    chk("brk_set", {6'h0, brk0, ferr0}, 8'h02);
    clear_all();
    chk("brk_cleared", {7'h0, brk0}, 8'h00);
`else
    chk("zero_frame_ferr", {7'h0, ferr0}, 8'h01);
    clear_all();
`endif
  endtask

  task automatic test_back_to_back();
    mode(1'b1, 1'b0, 1'b0);
    send({1'b1, 1'b1, 8'h11}, 9, 1'b0);
    chk("b2b_first_no_ovf", {7'h0, ovf0}, 8'h00);
    send({1'b1, 1'b1, 8'h22}, 9, 1'b0);
    chk("ovf_set", {6'h0, ovf0, ovf1}, 8'h03);
    chk("ovf_overwrite_data", data0, 8'h22);
    chk("ovf_keep_old_data", data1, 8'h11);
    clear_all();
    send({1'b1, 1'b1, 8'h11}, 9, 1'b0);
    send({1'b1, 1'b1, 8'h22}, 9, 1'b1);
    chk("rd_at_done_flags", {4'h0, rxrdy0, ovf0, rxrdy1, ovf1}, 8'h0A);
    chk("rd_at_done_data", data1, 8'h22);
    clear_all();
  endtask

  task automatic test_mid_frame_reset();
    mode(1'b1, 1'b0, 1'b0);
    send({1'b1, 1'b1, 8'h77}, 9, 1'b0);
    start = 1'b1; btu = 1'b1; cyc(); btu = 1'b0; start = 1'b0; cyc();
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0; btu = 1'b1; cyc();
      btu = 1'b0; cyc();
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_data", data0, 8'h00);
    chk("midrst_flags", {4'h0, rxrdy0, perr0, ferr0, ovf0}, 8'h00);
    send({1'b1, 1'b1, 8'h5A}, 9, 1'b0);
    chk("after_rst_data", data0, 8'h5A);
    chk("after_rst_flags", {4'h0, rxrdy0, perr0, ferr0, ovf0}, 8'h08);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; start = 1'b0; btu = 1'b0; done = 1'b0;
    eight = 1'b1; p_en = 1'b0; ohel = 1'b0; rd_data = 1'b0; rd_stat = 1'b0;
    test_reset();
    test_8p_odd();
    test_7bit();
    test_parity();
    test_framing();
    test_back_to_back();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
